// File: rtl/avmm_mem_responder.sv
// Avalon-MM slave memory that serves a read/write master port. Reads have a fixed latency,
// writes honour byte enables, every access is range/alignment checked, and accesses are counted.
module avmm_mem_responder #(
  parameter int          DEPTH_LOG2   = 10,
  parameter logic [63:0] BASE_ADDR    = 64'h0,
  parameter int          READ_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] avs_address,
  input  logic [7:0]  avs_byteenable,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [63:0] avs_writedata,
  output logic [63:0] avs_readdata,
  output logic        avs_readdatavalid,
  input  logic        clear_counts,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic        oob_error
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int L     = READ_LATENCY;

  logic [64:0]           diff;
  logic [63:0]           off;
  logic                  acc_ok;
  logic [DEPTH_LOG2-1:0] idx;

  // The extra top bit is the borrow, i.e. the address lies below BASE_ADDR.
  assign diff   = {1'b0, avs_address} - {1'b0, BASE_ADDR};
  assign off    = diff[63:0];
  assign idx    = off[DEPTH_LOG2+2:3];
  assign acc_ok = !diff[64] && (off[63:DEPTH_LOG2+3] == '0) && (off[2:0] == 3'b000);

  logic [63:0] mem_q [DEPTH];

  // Contents are deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (avs_write && acc_ok) begin
      for (int b = 0; b < 8; b++) begin
        if (avs_byteenable[b]) mem_q[idx][8*b +: 8] <= avs_writedata[8*b +: 8];
      end
    end
  end

  logic [L:1]        vld_pipe_q, vld_pipe_d;
  logic [L:1][63:0]  dat_pipe_q, dat_pipe_d;
  logic [31:0]       rd_count_q, rd_count_d;
  logic [31:0]       wr_count_q, wr_count_d;
  logic              oob_q, oob_d;

  // Stage 1 samples the array before this edge's write lands, giving read-before-write.
  // Data is zeroed whenever its valid bit is low, so the output needs no extra gating.
  always_comb begin
    vld_pipe_d    = '0;
    dat_pipe_d    = '0;
    vld_pipe_d[1] = avs_read;
    dat_pipe_d[1] = (avs_read && acc_ok) ? mem_q[idx] : 64'h0;
    for (int i = 2; i <= L; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      dat_pipe_d[i] = dat_pipe_q[i-1];
    end
  end

  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    oob_d      = oob_q;
    if (clear_counts) begin
      rd_count_d = '0;
      wr_count_d = '0;
      oob_d      = 1'b0;
    end else begin
      if (avs_read  && rd_count_q != '1) rd_count_d = rd_count_q + 32'd1;
      if (avs_write && wr_count_q != '1) wr_count_d = wr_count_q + 32'd1;
      if ((avs_read || avs_write) && !acc_ok) oob_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
      oob_q      <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      dat_pipe_q <= dat_pipe_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
      oob_q      <= oob_d;
    end
  end

  assign avs_readdatavalid = vld_pipe_q[L];
  assign avs_readdata      = dat_pipe_q[L];
  assign rd_count          = rd_count_q;
  assign wr_count          = wr_count_q;
  assign oob_error         = oob_q;
endmodule

// File: tb/tb_avmm_mem_responder.sv
// Randomized bench for avmm_mem_responder: a reference memory model schedules expected
// responses into queues; monitors compare every cycle's readdata/readdatavalid against them.
module tb_avmm_mem_responder;
  localparam int          DL   = 10;
  localparam int          DEP  = 1 << DL;
  localparam logic [63:0] BASE = 64'h1000;
  localparam int          LAT  = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] avs_address = '0, avs_writedata = '0;
  logic [7:0]  avs_byteenable = '0;
  logic        avs_read = 1'b0, avs_write = 1'b0, clear_counts = 1'b0;
  logic [63:0] avs_readdata;
  logic        avs_readdatavalid, oob_error;
  logic [31:0] rd_count, wr_count;

  // second instance with single-cycle latency
  logic [63:0] s_address = '0, s_writedata = '0, s_readdata;
  logic        s_read = 1'b0, s_write = 1'b0, s_rdv, s_oob;
  logic [31:0] s_rdc, s_wrc;

  avmm_mem_responder #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE), .READ_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .avs_address(avs_address), .avs_byteenable(avs_byteenable),
    .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .clear_counts(clear_counts), .rd_count(rd_count), .wr_count(wr_count), .oob_error(oob_error));

  avmm_mem_responder #(.DEPTH_LOG2(4), .BASE_ADDR(64'h0), .READ_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .avs_address(s_address), .avs_byteenable(8'hFF),
    .avs_read(s_read), .avs_write(s_write), .avs_writedata(s_writedata),
    .avs_readdata(s_readdata), .avs_readdatavalid(s_rdv),
    .clear_counts(1'b0), .rd_count(s_rdc), .wr_count(s_wrc), .oob_error(s_oob));

  always #5 clock = ~clock;

  typedef struct { int due; logic [63:0] data; } exp_t;
  exp_t q2[$];
  exp_t q1[$];

  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [63:0] mm [DEP];
  logic [31:0] m_rd = 0, m_wr = 0;
  logic        m_oob = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit addr_ok(input logic [63:0] a);
    logic [63:0] o;
    o = a - BASE;
    return (a >= BASE) && ((o >> 3) < 64'(DEP)) && (a % 8 == 0);
  endfunction

  function automatic int widx(input logic [63:0] a);
    return int'((a - BASE) >> 3);
  endfunction

  // One bus cycle: model the expected effect, then let the edge happen and check counters.
  task automatic drv(input logic rd, input logic wr, input logic [63:0] a, input logic [7:0] be,
                     input logic [63:0] wd, input logic clr);
    bit ok;
    ok = addr_ok(a);
    avs_read = rd; avs_write = wr; avs_address = a; avs_byteenable = be;
    avs_writedata = wd; clear_counts = clr;
    if (rd) q2.push_back('{cyc + LAT, ok ? mm[widx(a)] : 64'h0});
    if (wr && ok)
      for (int b = 0; b < 8; b++) if (be[b]) mm[widx(a)][8*b +: 8] = wd[8*b +: 8];
    if (clr) begin
      m_rd = 0; m_wr = 0; m_oob = 0;
    end else begin
      if (rd && m_rd != 32'hFFFFFFFF) m_rd++;
      if (wr && m_wr != 32'hFFFFFFFF) m_wr++;
      if ((rd || wr) && !ok) m_oob = 1;
    end
    @(posedge clock); #1;
    avs_read = 0; avs_write = 0; clear_counts = 0;
    chk("rd_count", 64'(rd_count), 64'(m_rd));
    chk("wr_count", 64'(wr_count), 64'(m_wr));
    chk("oob_error", 64'(oob_error), 64'(m_oob));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, BASE, 8'h00, 64'h0, 0);
  endtask

  always @(negedge clock) begin
    if (reset) begin
      chk("rdv_in_reset", 64'(avs_readdatavalid), 64'h0);
    end else if (q2.size() > 0 && q2[0].due == cyc) begin
      chk("rdv", 64'(avs_readdatavalid), 64'h1);
      chk("rdata", avs_readdata, q2[0].data);
      void'(q2.pop_front());
    end else begin
      chk("rdv_idle", 64'(avs_readdatavalid), 64'h0);
      chk("rdata_idle", avs_readdata, 64'h0);
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (q1.size() > 0 && q1[0].due == cyc) begin
        chk("lat1_rdv", 64'(s_rdv), 64'h1);
        chk("lat1_rdata", s_readdata, q1[0].data);
        void'(q1.pop_front());
      end else begin
        chk("lat1_rdv_idle", 64'(s_rdv), 64'h0);
      end
    end
  end

  initial begin
    logic [63:0] a;
    #1;
    chk("reset_rdata", avs_readdata, 64'h0);
    chk("reset_rdv", 64'(avs_readdatavalid), 64'h0);
    chk("reset_rd_count", 64'(rd_count), 64'h0);
    chk("reset_wr_count", 64'(wr_count), 64'h0);
    chk("reset_oob", 64'(oob_error), 64'h0);
    repeat (3) @(posedge clock);
    #1 reset = 0;

    // full write then read back; partial write overlay
    drv(0, 1, BASE + 8, 8'hFF, 64'h1122334455667788, 0);
    drv(1, 0, BASE + 8, 8'h00, 64'h0, 0);
    idle(3);
    drv(0, 1, BASE + 8, 8'h0F, 64'hAAAAAAAABBBBBBBB, 0);
    drv(1, 0, BASE + 8, 8'h00, 64'h0, 0);
    chk("partial_model", mm[1], 64'h11223344BBBBBBBB);
    idle(3);

    // preload every word so random reads always hit defined data
    for (int i = 0; i < DEP; i++)
      drv(0, 1, BASE + 64'(8 * i), 8'hFF, (i < 8) ? 64'(i * 3) : {$urandom, $urandom}, 0);
    drv(0, 0, BASE, 8'h00, 64'h0, 1);

    // back-to-back burst
    for (int i = 0; i < 8; i++) drv(1, 0, BASE + 64'(8 * i), 8'h00, 64'h0, 0);
    idle(4);

    // out-of-range, misaligned, below base; then clear
    drv(1, 0, BASE + 64'(8 * DEP), 8'h00, 64'h0, 0);
    drv(1, 0, BASE + 4, 8'h00, 64'h0, 0);
    idle(3);
    drv(0, 1, BASE - 8, 8'hFF, 64'hDEAD, 0);
    drv(0, 0, BASE, 8'h00, 64'h0, 1);
    idle(2);

    // read-before-write on word 5
    drv(0, 1, BASE + 40, 8'hFF, 64'h5, 0);
    drv(0, 0, BASE, 8'h00, 64'h0, 1);
    drv(1, 1, BASE + 40, 8'hFF, 64'h9, 0);
    drv(1, 0, BASE + 40, 8'h00, 64'h0, 0);
    idle(3);

    // random traffic, including occasional bad addresses and clears
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE + 64'(8 * DEP) + 64'(8 * $urandom_range(0, 100));
        1:       a = BASE + 64'(8 * $urandom_range(0, DEP - 1)) + 64'($urandom_range(1, 7));
        2:       a = BASE - 64'(8 * $urandom_range(1, 4));
        default: a = BASE + 64'(8 * $urandom_range(0, DEP - 1));
      endcase
      drv(1'($urandom), 1'($urandom), a, 8'($urandom), {$urandom, $urandom},
          ($urandom_range(0, 31) == 0));
    end
    idle(4);

    // read in flight when reset pulses must never be answered
    drv(1, 0, BASE + 16, 8'h00, 64'h0, 0);
    reset = 1;
    q2.delete();
    m_rd = 0; m_wr = 0; m_oob = 0;
    @(posedge clock); #1;
    reset = 0;
    chk("post_reset_rd_count", 64'(rd_count), 64'h0);
    chk("post_reset_oob", 64'(oob_error), 64'h0);
    idle(4);

    // single-cycle latency: write then immediate read of the same word
    s_write = 1; s_address = 64'd24; s_writedata = 64'hCAFEF00D12345678;
    @(posedge clock); #1;
    s_write = 0; s_read = 1;
    q1.push_back('{cyc + 1, 64'hCAFEF00D12345678});
    @(posedge clock); #1;
    s_read = 0;
    idle(4);

    chk("q2_drained", 64'(q2.size()), 64'h0);
    chk("q1_drained", 64'(q1.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
